mul_stream_engine: RTL and testbench
====================================

MUL_STREAM_ENGINE -- requirements
Module: mul_stream_engine

Interface
REQ-001 SHALL have parameter OP_W, default 64: operand width in bits.
REQ-002 SHALL have parameter LANE_W, default 4: input beat width per operand; OP_W % LANE_W == 0 required.
REQ-003 SHALL have parameter OUT_W, default 8: output chunk width; (2*OP_W) % OUT_W == 0 required.
REQ-004 SHALL have parameters OP_DEPTH, default 4, and PROD_DEPTH, default 8: operand-pair and product FIFO depths, each a power of two and at least 2.
REQ-005 SHALL have port clk, input, 1: the single clock.
REQ-006 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have ports in_valid (input, 1), in_ready (output, 1), in_a (input, LANE_W) and in_b (input, LANE_W): operand beat handshake.
REQ-008 SHALL have ports mul_start (output, 1), mul_a (output, OP_W), mul_b (output, OP_W), mul_p (input, 2*OP_W) and mul_done (input, 1): external multiplier handshake.
REQ-009 SHALL have ports out_valid (output, 1), out_ready (input, 1), out_data (output, OUT_W) and out_last (output, 1): product stream.
REQ-010 SHALL have port busy, output, 1: high when any FIFO is non-empty, assembly is mid-word, FSM is not IDLE, or the serialiser holds a product.

Function
REQ-011 SHALL accept a beat on every edge where in_valid && in_ready.
REQ-012 SHALL assemble OP_W/LANE_W beats per operand, first beat into the most significant lane.
REQ-013 SHALL push {a,b} into the operand FIFO on the edge that accepts the final beat.
REQ-014 SHALL drive in_ready = (operand FIFO count < OP_DEPTH); mid-word in_ready therefore stays high.
REQ-015 SHALL run a multiplier FSM with states IDLE, LAUNCH, WAIT.
REQ-016 IDLE SHALL go to LAUNCH when the operand FIFO is non-empty and product FIFO count < PROD_DEPTH.
REQ-017 LAUNCH SHALL register mul_a/mul_b from the FIFO head, pop it, pulse mul_start for exactly one cycle, then go to WAIT.
REQ-018 mul_a/mul_b SHALL hold stable until the next LAUNCH.
REQ-019 First mul_start SHALL occur in the cycle after the second edge following final-beat acceptance.
REQ-020 WAIT SHALL push mul_p into the product FIFO on mul_done, then go to IDLE; mul_done outside WAIT SHALL be ignored.
REQ-021 Serialiser SHALL load the product FIFO head when empty, emitting LSB chunk first, advancing one chunk per out_valid && out_ready.
REQ-022 Serialiser SHALL assert out_last on chunk (2*OP_W/OUT_W)-1 and hold out_data/out_valid stable while out_ready is low.
REQ-023 Serialiser SHALL reload on the same edge as the last-chunk handshake if the product FIFO is non-empty, giving zero bubble.
REQ-024 Simultaneous push and pop on either FIFO SHALL leave its count unchanged; pointers SHALL wrap modulo depth.
REQ-025 Products SHALL leave in operand arrival order; no data SHALL ever be dropped or overwritten.

Reset
REQ-026 While rst_n is low, all outputs SHALL be 0, FSM IDLE, FIFOs empty, and the lane counter 0.
REQ-027 Reset mid-word, mid-multiply or mid-serialisation SHALL discard that data; the first post-reset beat SHALL be the MS lane of a new word.

Configuration
REQ-028 With MUL_STREAM_CNT_EN defined, the block SHALL add output prod_cnt[31:0], reset 0, incremented per product-FIFO push and wrapping at 2^32.
REQ-029 Without MUL_STREAM_CNT_EN, neither the port nor the counter SHALL exist.

Structure
REQ-030 Package mul_stream_pkg SHALL hold the FSM state enum and the default parameter constants.
REQ-031 A parametrised sub-module sync_fifo (WIDTH, DEPTH, count output) SHALL implement both FIFOs.

Verification
REQ-032 A=0x3, B=0x5 in 16 beats, mul_p=0xF after 10 cycles: bytes 0x0F then 15x 0x00, out_last on byte 16.
REQ-033 A=B=0xFFFF_FFFF_FFFF_FFFF, mul_p=0xFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001: first byte 0x01, byte 8 0xFE, last byte 0xFF.
REQ-034 Ten pairs with out_ready low for 200 cycles: in_ready drops once 4 pairs queue and FSM stalls at 8 products; after release, all 10 products emerge in order, none lost.
REQ-035 rst_n low after 7 beats, then one full pair: only that pair's product is output; mul_start pulses once.
REQ-036 mul_done pulsed in IDLE: no product pushed, no output.
REQ-037 With MUL_STREAM_CNT_EN defined, three pairs give prod_cnt == 3 after the third mul_done; after reset it reads 0.

Source files
------------

// File: rtl/mul_stream_pkg.sv
// Shared FSM state type and default parameter values for the multiply stream engine.
package mul_stream_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StLaunch,
        StWait
    } mul_state_e;

    localparam int unsigned OP_W_DEF       = 64;
    localparam int unsigned LANE_W_DEF     = 4;
    localparam int unsigned OUT_W_DEF      = 8;
    localparam int unsigned OP_DEPTH_DEF   = 4;
    localparam int unsigned PROD_DEPTH_DEF = 8;

endpackage

// File: rtl/mul_stream_engine_fifo.sv
// Synchronous FIFO with occupancy count; DEPTH must be a power of two so pointers wrap naturally.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned CW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata,
    output logic [CW-1:0]    o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push  = i_push && (r_count != CW'(DEPTH));
    assign w_pop   = i_pop && (r_count != '0);
    assign o_rdata = r_mem[r_rd_ptr];
    assign o_count = r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_wdata;
    end

endmodule

// File: rtl/mul_stream_engine.sv
// Assembles lane-serial operand pairs, drives an external multiplier and serialises products.
// Optional MUL_STREAM_CNT_EN adds a wrapping 32-bit product counter output prod_cnt.
module mul_stream_engine
    import mul_stream_pkg::*;
#(
    parameter int unsigned OP_W       = OP_W_DEF,
    parameter int unsigned LANE_W     = LANE_W_DEF,
    parameter int unsigned OUT_W      = OUT_W_DEF,
    parameter int unsigned OP_DEPTH   = OP_DEPTH_DEF,
    parameter int unsigned PROD_DEPTH = PROD_DEPTH_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [LANE_W-1:0]   in_a,
    input  logic [LANE_W-1:0]   in_b,
    output logic                mul_start,
    output logic [OP_W-1:0]     mul_a,
    output logic [OP_W-1:0]     mul_b,
    input  logic [2*OP_W-1:0]   mul_p,
    input  logic                mul_done,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OUT_W-1:0]    out_data,
    output logic                out_last,
    output logic                busy
`ifdef MUL_STREAM_CNT_EN
    ,
    output logic [31:0]         prod_cnt
`endif
);

    localparam int unsigned BEATS  = OP_W / LANE_W;
    localparam int unsigned LCW    = $clog2(BEATS + 1);
    localparam int unsigned CHUNKS = (2 * OP_W) / OUT_W;
    localparam int unsigned CCW    = $clog2(CHUNKS + 1);
    localparam int unsigned OCW    = $clog2(OP_DEPTH) + 1;
    localparam int unsigned PCW    = $clog2(PROD_DEPTH) + 1;

    // Operand assembly
    logic [LCW-1:0]    r_lane_cnt;
    logic [OP_W-1:0]   r_a_sh;
    logic [OP_W-1:0]   r_b_sh;
    logic [OP_W-1:0]   w_a_next;
    logic [OP_W-1:0]   w_b_next;
    logic              w_in_fire;
    logic              w_word_done;
    logic [OCW-1:0]    w_op_cnt;
    logic [2*OP_W-1:0] w_op_head;
    logic              w_op_pop;

    assign in_ready    = rst_n && (w_op_cnt < OCW'(OP_DEPTH));
    assign w_in_fire   = in_valid && in_ready;
    assign w_a_next    = (r_a_sh << LANE_W) | OP_W'(in_a);
    assign w_b_next    = (r_b_sh << LANE_W) | OP_W'(in_b);
    assign w_word_done = w_in_fire && (r_lane_cnt == LCW'(BEATS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lane_cnt <= '0;
            r_a_sh     <= '0;
            r_b_sh     <= '0;
        end else if (w_in_fire) begin
            r_a_sh     <= w_a_next;
            r_b_sh     <= w_b_next;
            r_lane_cnt <= w_word_done ? '0 : r_lane_cnt + 1'b1;
        end
    end

    sync_fifo #(
        .WIDTH (2 * OP_W),
        .DEPTH (OP_DEPTH)
    ) u_op_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_word_done),
        .i_pop   (w_op_pop),
        .i_wdata ({w_a_next, w_b_next}),
        .o_rdata (w_op_head),
        .o_count (w_op_cnt)
    );

    // Multiplier control
    mul_state_e        r_state;
    mul_state_e        w_state_next;
    logic              r_mul_start;
    logic [OP_W-1:0]   r_mul_a;
    logic [OP_W-1:0]   r_mul_b;
    logic              w_prod_push;
    logic [PCW-1:0]    w_prod_cnt;
    logic [2*OP_W-1:0] w_prod_head;
    logic              w_prod_pop;

    always_comb begin
        w_state_next = r_state;
        w_op_pop     = 1'b0;
        w_prod_push  = 1'b0;
        unique case (r_state)
            StIdle: begin
                // Only launch when the result is guaranteed a product FIFO slot.
                if ((w_op_cnt != '0) && (w_prod_cnt < PCW'(PROD_DEPTH))) begin
                    w_state_next = StLaunch;
                end
            end
            StLaunch: begin
                w_op_pop     = 1'b1;
                w_state_next = StWait;
            end
            StWait: begin
                if (mul_done) begin
                    w_prod_push  = 1'b1;
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_mul_start <= 1'b0;
            r_mul_a     <= '0;
            r_mul_b     <= '0;
        end else begin
            r_state     <= w_state_next;
            r_mul_start <= (r_state == StLaunch);
            if (r_state == StLaunch) begin
                r_mul_a <= w_op_head[2*OP_W-1:OP_W];
                r_mul_b <= w_op_head[OP_W-1:0];
            end
        end
    end

    assign mul_start = r_mul_start;
    assign mul_a     = r_mul_a;
    assign mul_b     = r_mul_b;

    sync_fifo #(
        .WIDTH (2 * OP_W),
        .DEPTH (PROD_DEPTH)
    ) u_prod_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_prod_push),
        .i_pop   (w_prod_pop),
        .i_wdata (mul_p),
        .o_rdata (w_prod_head),
        .o_count (w_prod_cnt)
    );

    // Serialiser
    logic              r_ser_valid;
    logic [2*OP_W-1:0] r_ser_data;
    logic [CCW-1:0]    r_chunk;
    logic              w_out_fire;
    logic              w_last;

    assign w_out_fire = r_ser_valid && out_ready;
    assign w_last     = (r_chunk == CCW'(CHUNKS - 1));
    // Reloading on the final handshake keeps back-to-back products gap-free.
    assign w_prod_pop = (w_prod_cnt != '0) && (!r_ser_valid || (w_out_fire && w_last));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ser_valid <= 1'b0;
            r_ser_data  <= '0;
            r_chunk     <= '0;
        end else if (w_prod_pop) begin
            r_ser_valid <= 1'b1;
            r_ser_data  <= w_prod_head;
            r_chunk     <= '0;
        end else if (w_out_fire) begin
            if (w_last) begin
                r_ser_valid <= 1'b0;
            end else begin
                r_ser_data <= r_ser_data >> OUT_W;
                r_chunk    <= r_chunk + 1'b1;
            end
        end
    end

    assign out_valid = r_ser_valid;
    assign out_data  = r_ser_data[OUT_W-1:0];
    assign out_last  = r_ser_valid && w_last;

    assign busy = (w_op_cnt != '0) || (w_prod_cnt != '0) || (r_lane_cnt != '0) ||
                  (r_state != StIdle) || r_ser_valid;

`ifdef MUL_STREAM_CNT_EN
    logic [31:0] r_prod_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prod_cnt <= '0;
        end else if (w_prod_push) begin
            r_prod_cnt <= r_prod_cnt + 32'd1;
        end
    end

    assign prod_cnt = r_prod_cnt;
`endif

endmodule

// File: tb/tb_mul_stream_engine.sv
// Randomised self-checking bench for mul_stream_engine with a behavioural multiplier model.
module tb_mul_stream_engine;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   in_a;
    logic [3:0]   in_b;
    logic         mul_start;
    logic [63:0]  mul_a;
    logic [63:0]  mul_b;
    logic [127:0] mul_p;
    logic         mul_done;
    logic         out_valid;
    logic         out_ready;
    logic [7:0]   out_data;
    logic         out_last;
    logic         busy;
`ifdef MUL_STREAM_CNT_EN
    logic [31:0]  prod_cnt;
`endif

    mul_stream_engine u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .mul_start (mul_start),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_p     (mul_p),
        .mul_done  (mul_done),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy)
`ifdef MUL_STREAM_CNT_EN
        ,
        .prod_cnt  (prod_cnt)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [127:0] exp_q [$];
    logic [127:0] op_q  [$];
    int  n_out       = 0;
    int  n_start_cyc = 0;
    int  mul_lat     = 10;
    bit  lat_rand    = 0;
    bit  rdy_rand    = 0;
    bit  rdy_val     = 1;
    bit  spur_req    = 0;
    bit  saw_full    = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [127:0] mul_ref(input logic [63:0] a, input logic [63:0] b);
        return {64'd0, a} * {64'd0, b};
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = rdy_rand ? 1'($urandom % 2) : rdy_val;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (mul_start) n_start_cyc++;
        end
    end

    // Multiplier model: checks the launched operands against arrival order, answers a*b later.
    initial begin
        logic [63:0] ca;
        logic [63:0] cb;
        logic [127:0] exp_op;
        int lat;
        mul_done = 1'b0;
        mul_p    = '0;
        forever begin
            @(posedge clk);
            #1;
            if (spur_req) begin
                mul_p    = 128'hDEAD_BEEF;
                mul_done = 1'b1;
                @(posedge clk);
                #1;
                mul_done = 1'b0;
                spur_req = 0;
            end else if (mul_start && rst_n) begin
                ca = mul_a;
                cb = mul_b;
                if (op_q.size() == 0) begin
                    check_eq("unexpected_launch", 1, 0);
                end else begin
                    exp_op = op_q.pop_front();
                    check_eq("mul_a", {64'd0, ca}, {64'd0, exp_op[127:64]});
                    check_eq("mul_b", {64'd0, cb}, {64'd0, exp_op[63:0]});
                end
                lat = lat_rand ? int'($urandom_range(0, 15)) : mul_lat;
                repeat (lat) begin
                    @(posedge clk);
                    #1;
                end
                mul_p    = mul_ref(ca, cb);
                mul_done = 1'b1;
                @(posedge clk);
                #1;
                mul_done = 1'b0;
            end
        end
    end

    // Output monitor: rebuilds products LSB chunk first and compares against arrival order.
    initial begin
        int idx;
        logic [127:0] acc;
        logic [127:0] exp_p;
        bit hold;
        logic [7:0] held;
        idx  = 0;
        acc  = '0;
        hold = 0;
        held = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                idx  = 0;
                hold = 0;
            end else begin
                if (hold) begin
                    check_eq("hold_valid", {127'd0, out_valid}, 1);
                    check_eq("hold_data", {120'd0, out_data}, {120'd0, held});
                end
                hold = out_valid && !out_ready;
                held = out_data;
                if (out_valid && out_ready) begin
                    check_eq("out_last", {127'd0, out_last}, {127'd0, idx == 15});
                    acc[idx*8 +: 8] = out_data;
                    if (idx == 15) begin
                        idx = 0;
                        n_out++;
                        if (exp_q.size() == 0) begin
                            check_eq("unexpected_product", acc, 0);
                        end else begin
                            exp_p = exp_q.pop_front();
                            check_eq("product", acc, exp_p);
                        end
                    end else begin
                        idx++;
                    end
                end
            end
        end
    end

    task automatic send_beats(input logic [63:0] a, input logic [63:0] b, input int nbeats);
        for (int i = 0; i < nbeats; i++) begin
            int t;
            t        = 0;
            in_valid = 1'b1;
            in_a     = a[63-4*i -: 4];
            in_b     = b[63-4*i -: 4];
            @(negedge clk);
            while (!in_ready && t < 3000) begin
                saw_full = 1;
                @(negedge clk);
                t++;
            end
            if (!in_ready) check_eq("in_ready_timeout", 0, 1);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (nbeats == 16) begin
            op_q.push_back({a, b});
            exp_q.push_back(mul_ref(a, b));
        end
    endtask

    task automatic send_pair(input logic [63:0] a, input logic [63:0] b);
        send_beats(a, b, 16);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((busy || exp_q.size() != 0) && t < 5000) begin
            @(posedge clk);
            #1;
            t++;
        end
        check_eq("drain_in_time", {127'd0, t < 5000}, 1);
    endtask

    task automatic do_reset();
        #1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_in_ready", {127'd0, in_ready}, 0);
        check_eq("rst_out_valid", {127'd0, out_valid}, 0);
        check_eq("rst_out_last", {127'd0, out_last}, 0);
        check_eq("rst_out_data", {120'd0, out_data}, 0);
        check_eq("rst_mul_start", {127'd0, mul_start}, 0);
        check_eq("rst_mul_a", {64'd0, mul_a}, 0);
        check_eq("rst_busy", {127'd0, busy}, 0);
        exp_q.delete();
        op_q.delete();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int base_out;
        int base_start;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_a     = '0;
        in_b     = '0;
        do_reset();

        // Small product with first-launch timing.
        mul_lat = 10;
        send_pair(64'h3, 64'h5);
        @(posedge clk); #1;
        check_eq("start_edge1", {127'd0, mul_start}, 0);
        @(posedge clk); #1;
        check_eq("start_edge2", {127'd0, mul_start}, 1);
        @(posedge clk); #1;
        check_eq("start_edge3", {127'd0, mul_start}, 0);
        wait_idle();
        check_eq("n_out_small", n_out, 1);
        check_eq("ref_small", mul_ref(64'h3, 64'h5), 128'hF);

        // All-ones operands.
        send_pair('1, '1);
        wait_idle();
        check_eq("n_out_ones", n_out, 2);

        // Spurious mul_done while idle.
        spur_req = 1;
        repeat (30) @(posedge clk);
        #1;
        check_eq("spur_no_out", n_out, 2);
        check_eq("spur_idle", {127'd0, busy}, 0);

        // Backpressure: ten pairs with output stalled.
        rdy_val    = 0;
        mul_lat    = 40;
        saw_full   = 0;
        base_start = n_start_cyc;
        fork
            for (int k = 0; k < 10; k++) send_pair({$urandom, $urandom}, {$urandom, $urandom});
            repeat (600) @(posedge clk);
        join
        repeat (100) @(posedge clk);
        #1;
        check_eq("bp_in_ready_dropped", {127'd0, saw_full}, 1);
        check_eq("bp_launches_stalled", n_start_cyc - base_start, 9);
        check_eq("bp_none_out", n_out, 2);
        rdy_val = 1;
        wait_idle();
        check_eq("bp_all_out", n_out, 12);

        // Reset mid-word discards the partial operand.
        mul_lat = 10;
        send_beats(64'hAAAA_BBBB_CCCC_DDDD, 64'h1111_2222_3333_4444, 7);
        do_reset();
        base_start = n_start_cyc;
        base_out   = n_out;
        send_pair(64'h1234_5678, 64'h9);
        wait_idle();
        check_eq("rst_one_launch", n_start_cyc - base_start, 1);
        check_eq("rst_one_out", n_out - base_out, 1);

        // Random traffic with random output backpressure and multiplier latency.
        rdy_rand = 1;
        lat_rand = 1;
        base_out = n_out;
        for (int k = 0; k < 20; k++) begin
            send_pair({$urandom, $urandom}, {$urandom, $urandom});
            repeat ($urandom_range(0, 20)) @(posedge clk);
            #1;
        end
        wait_idle();
        rdy_rand = 0;
        lat_rand = 0;
        check_eq("rand_all_out", n_out - base_out, 20);

`ifdef MUL_STREAM_CNT_EN
        do_reset();
        for (int k = 0; k < 3; k++) send_pair({$urandom, $urandom}, {$urandom, $urandom});
        wait_idle();
        check_eq("prod_cnt_three", {96'd0, prod_cnt}, 3);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_eq("prod_cnt_reset", {96'd0, prod_cnt}, 0);
        rst_n = 1'b1;
`endif

        check_eq("exp_q_empty", exp_q.size(), 0);
        check_eq("op_q_empty", op_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
